// File: rtl/control_unit.sv
// Multi-cycle FSM controller for the accumulator machine.
// Owns PC/IR, fetches, decodes and sequences datapath strobes.
module control_unit #(
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [DATA_WIDTH-1:0]    instruction_in,
  output logic [OPERAND_WIDTH-1:0] instruction_address_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic                     alu_op_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     acc_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_wr_out,
  output logic                     status_reset_out,
  output logic                     data_memory_wr_out,
  input  logic                     status_Z_in,
  input  logic                     status_N_in,
  output logic                     halted_out
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, WRITE, HALT
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(12);

  state_t state, state_next;
  logic [OPERAND_WIDTH-1:0] pc, pc_next;
  logic [DATA_WIDTH-1:0] ir;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [1:0] sel_a_d;
  logic sel_b_d, alu_d, wr_d, taken;

  assign opcode = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand_out = ir[OPERAND_WIDTH-1:0];
  assign instruction_address_out = pc;
  assign acc_reset_out = reset_in;
  assign status_reset_out = reset_in;
  assign halted_out = (state == HALT);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
    end else begin
      state <= state_next;
      pc <= pc_next;
      if (state == DECODE) ir <= instruction_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = (opcode == OP_HLT) ? HALT : WRITE;
      WRITE:   state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    sel_a_d = 2'b00;
    sel_b_d = 1'b0;
    alu_d = 1'b0;
    wr_d = 1'b0;
    taken = 1'b0;
    case (opcode)
      OP_LD:   begin sel_a_d = 2'b10; wr_d = 1'b1; end
      OP_LDI:  begin sel_a_d = 2'b01; wr_d = 1'b1; end
      OP_ADD:  wr_d = 1'b1;
      OP_ADDI: begin sel_b_d = 1'b1; wr_d = 1'b1; end
      OP_SUB:  begin alu_d = 1'b1; wr_d = 1'b1; end
      OP_SUBI: begin
        sel_b_d = 1'b1;
        alu_d = 1'b1;
        wr_d = 1'b1;
      end
      OP_BEQ:  taken = status_Z_in;
      OP_BNE:  taken = !status_Z_in;
      OP_BLT:  taken = status_N_in;
      OP_BGE:  taken = !status_N_in;
      OP_JMP:  taken = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (state == WRITE)
      pc_next = taken ? operand_out : pc + OPERAND_WIDTH'(1);
  end

  // Strobes are gated by reset so an aborted instruction never commits.
  always_comb begin
    sel_A_out = 2'b00;
    sel_B_out = 1'b0;
    alu_op_out = 1'b0;
    acc_wr_out = 1'b0;
    status_wr_out = 1'b0;
    data_memory_wr_out = 1'b0;
    if (!reset_in) begin
      case (state)
        EXEC: begin
          sel_A_out = sel_a_d;
          sel_B_out = sel_b_d;
          alu_op_out = alu_d;
          data_memory_wr_out = (opcode == OP_STO);
        end
        WRITE: begin
          sel_A_out = sel_a_d;
          sel_B_out = sel_b_d;
          alu_op_out = alu_d;
          acc_wr_out = wr_d;
          status_wr_out = wr_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit.
// Registered instruction memory model; hand-computed expectations.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] instr;
  logic [10:0] addr, operand;
  logic alu_op, sel_b, acc_wr, acc_rst;
  logic st_wr, st_rst, dm_wr, z, n, halted;
  logic [1:0] sel_a;

  logic [15:0] imem [0:2047];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) instr <= imem[addr];

  control_unit dut (
    .clock_in(clk),
    .reset_in(rst),
    .instruction_in(instr),
    .instruction_address_out(addr),
    .operand_out(operand),
    .alu_op_out(alu_op),
    .sel_A_out(sel_a),
    .sel_B_out(sel_b),
    .acc_wr_out(acc_wr),
    .acc_reset_out(acc_rst),
    .status_wr_out(st_wr),
    .status_reset_out(st_rst),
    .data_memory_wr_out(dm_wr),
    .status_Z_in(z),
    .status_N_in(n),
    .halted_out(halted)
  );

  typedef struct {
    logic [15:0] ins;
    logic z;
    logic n;
    logic [1:0] sel_a;
    logic sel_b;
    logic alu_op;
    logic wr;
    logic dm_wr;
    logic [10:0] pc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_strobes"},
        {28'd0, acc_wr, st_wr, dm_wr, halted}, 32'd0);
  endtask

  logic [10:0] pc_exp;

  initial begin
    for (int i = 0; i < 2048; i++) imem[i] = 16'h6800;
    z = 1'b0;
    n = 1'b0;
    //          ins      z  n  selA  sB op wr dm pc
    vecs[0]  = '{16'h1805, 0, 0, 2'b01, 0, 0, 1, 0, 11'h001};
    vecs[1]  = '{16'h2803, 0, 0, 2'b00, 1, 0, 1, 0, 11'h002};
    vecs[2]  = '{16'h0810, 0, 0, 2'b00, 0, 0, 0, 1, 11'h003};
    vecs[3]  = '{16'h1010, 0, 0, 2'b10, 0, 0, 1, 0, 11'h004};
    vecs[4]  = '{16'h2010, 0, 0, 2'b00, 0, 0, 1, 0, 11'h005};
    vecs[5]  = '{16'h3010, 0, 0, 2'b00, 0, 1, 1, 0, 11'h006};
    vecs[6]  = '{16'h3801, 0, 0, 2'b00, 1, 1, 1, 0, 11'h007};
    vecs[7]  = '{16'h4020, 1, 0, 2'b00, 0, 0, 0, 0, 11'h020};
    vecs[8]  = '{16'h4030, 0, 0, 2'b00, 0, 0, 0, 0, 11'h021};
    vecs[9]  = '{16'h4840, 0, 0, 2'b00, 0, 0, 0, 0, 11'h040};
    vecs[10] = '{16'h5050, 0, 1, 2'b00, 0, 0, 0, 0, 11'h050};
    vecs[11] = '{16'h5860, 0, 1, 2'b00, 0, 0, 0, 0, 11'h051};
    vecs[12] = '{16'h5860, 0, 0, 2'b00, 0, 0, 0, 0, 11'h060};
    vecs[13] = '{16'h67FF, 0, 0, 2'b00, 0, 0, 0, 0, 11'h7FF};
    vecs[14] = '{16'h6800, 0, 0, 2'b00, 0, 0, 0, 0, 11'h000};

    // reset held two cycles
    step();
    chk("rst_acc_reset", {31'd0, acc_rst}, 32'd1);
    chk("rst_status_reset", {31'd0, st_rst}, 32'd1);
    step();
    rst = 1'b0;
    chk("rst_pc", {21'd0, addr}, 32'd0);
    chk("rst_sel", {28'd0, sel_a, sel_b, alu_op}, 32'd0);
    chk("rst_release", {30'd0, acc_rst, st_rst}, 32'd0);
    chk_quiet("rst");

    pc_exp = 11'h000;
    for (int i = 0; i < 15; i++) begin
      imem[pc_exp] = vecs[i].ins;
      z = vecs[i].z;
      n = vecs[i].n;
      chk($sformatf("v%0d_fetch_pc", i), {21'd0, addr}, {21'd0, pc_exp});
      chk_quiet($sformatf("v%0d_fetch", i));
      step();
      chk_quiet($sformatf("v%0d_decode", i));
      step();
      chk($sformatf("v%0d_exec_operand", i), {21'd0, operand},
          {21'd0, vecs[i].ins[10:0]});
      chk($sformatf("v%0d_exec_strobes", i),
          {28'd0, dm_wr, acc_wr, st_wr, halted},
          {28'd0, vecs[i].dm_wr, 3'b000});
      step();
      chk($sformatf("v%0d_write_sel", i),
          {28'd0, sel_a, sel_b, alu_op},
          {28'd0, vecs[i].sel_a, vecs[i].sel_b, vecs[i].alu_op});
      chk($sformatf("v%0d_write_strobes", i),
          {28'd0, acc_wr, st_wr, dm_wr, halted},
          {28'd0, vecs[i].wr, vecs[i].wr, 2'b00});
      step();
      pc_exp = vecs[i].pc;
    end
    chk("wrap_pc", {21'd0, addr}, 32'd0);

    // JMP 5, then reset during EXEC of ADD at 5
    imem[0] = 16'h6005;
    repeat (4) step();
    chk("jmp5_pc", {21'd0, addr}, 32'd5);
    imem[5] = 16'h2010;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_acc_wr", {30'd0, acc_wr, st_wr}, 32'd0);
    chk("mid_rst_acc_reset", {31'd0, acc_rst}, 32'd1);
    step();
    rst = 1'b0;
    chk("mid_rst_pc", {21'd0, addr}, 32'd0);
    chk_quiet("mid_rst_after");
    imem[0] = 16'h1807;
    step();
    step();
    chk("resume_exec_operand", {21'd0, operand}, 32'h007);
    step();
    chk("resume_write",
        {28'd0, sel_a, acc_wr, st_wr}, {28'd0, 2'b01, 2'b11});
    step();
    chk("resume_pc", {21'd0, addr}, 32'd1);

    // HLT at 1
    imem[1] = 16'h0000;
    step();
    step();
    chk("hlt_exec_halted", {31'd0, halted}, 32'd0);
    step();
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("halt%0d_pc", c), {21'd0, addr}, 32'd1);
      chk($sformatf("halt%0d_strobes", c),
          {28'd0, acc_wr, st_wr, dm_wr, halted}, 32'd1);
      step();
    end

    // reset out of HALT
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("unhalt_state", {31'd0, halted}, 32'd0);
    chk("unhalt_pc", {21'd0, addr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM controller that drives the accumulator datapath's control inputs.
- Owns the program counter (PC) and instruction register (IR), and fetches from instruction memory.
- Decodes 16-bit instructions (opcode[15:11], operand[10:0]) and sequences datapath and data-memory strobes.
- Consumes the datapath's Z/N status flags for conditional branches.

Parameters:
- OPCODE_WIDTH, 5, instruction opcode field width
- OPERAND_WIDTH, 11, operand field and PC/address width
- DATA_WIDTH, 16, instruction word width

Ports:
- clock_in  input  1  system clock, rising edge
- reset_in  input  1  synchronous, active-high reset
- instruction_in  input  DATA_WIDTH  instruction memory read data, valid 1 cycle after the address
- instruction_address_out  output  OPERAND_WIDTH  current PC
- operand_out  output  OPERAND_WIDTH  IR[10:0], to datapath operand_in
- alu_op_out  output  1  0=add, 1=sub
- sel_A_out  output  2  accumulator source: 00=ALU, 01=ext(operand), 10=data memory, 11=reserved
- sel_B_out  output  1  ALU B operand: 0=data memory, 1=ext(operand)
- acc_wr_out  output  1  accumulator write strobe
- acc_reset_out  output  1  accumulator clear
- status_wr_out  output  1  Z/N register write strobe
- status_reset_out  output  1  Z/N clear
- data_memory_wr_out  output  1  data memory write strobe (STO)
- status_Z_in  input  1  datapath zero flag
- status_N_in  input  1  datapath negative flag
- halted_out  output  1  high while in HALT

Behaviour:
- Opcodes:
  - 0 HLT
  - 1 STO
  - 2 LD
  - 3 LDI
  - 4 ADD
  - 5 ADDI
  - 6 SUB
  - 7 SUBI
  - 8 BEQ (Z=1)
  - 9 BNE (Z=0)
  - 10 BLT (N=1)
  - 11 BGE (N=0)
  - 12 JMP
  - 13-31 NOP
- Reset (sampled at the clock edge): PC=0, IR=0, state=FETCH, every strobe 0, sel_A=00, sel_B=0, alu_op=0, halted_out=0.
- acc_reset_out = status_reset_out = reset_in, combinational, so the datapath clears on the same edge.
- Reset mid-instruction aborts that instruction with no strobe; reset from HALT restarts at PC=0.
- States and transitions:
  - FETCH -> DECODE: instruction_address_out=PC.
  - DECODE -> EXEC: IR <= instruction_in.
  - EXEC -> WRITE, or -> HALT for HLT: operand_out holds IR operand and data memory reads it. STO asserts data_memory_wr_out for exactly this cycle.
  - WRITE -> FETCH: asserts the strobes below for exactly one cycle and updates PC.
  - HALT: absorbing; halted_out=1; PC frozen; no strobes.
- WRITE-cycle strobes (all other strobes 0):
  - LD: sel_A=10, acc_wr=1, status_wr=1.
  - LDI: sel_A=01, acc_wr=1, status_wr=1.
  - ADD/SUB: sel_A=00, sel_B=0, alu_op=0/1, acc_wr=1, status_wr=1.
  - ADDI/SUBI: as ADD/SUB but sel_B=1.
  - Branches, JMP, STO, NOP: no strobes.
- sel_A/sel_B/alu_op are held from EXEC through WRITE; they are don't-care elsewhere but driven to their reset values.
- PC update in WRITE:
  - Taken branch/JMP: PC <= operand.
  - Otherwise: PC <= PC+1 modulo 2^OPERAND_WIDTH, so 2047 wraps to 0.
- Branch flags are sampled in WRITE; they reflect the last status_wr.
- Latency: 4 cycles per instruction, HLT excepted; HLT reaches HALT after 3 cycles (FETCH, DECODE, EXEC).
- Instruction-memory read data is assumed registered (1-cycle read).

Test Plan:
- Reset: hold reset_in 2 cycles, release -> PC=0, every strobe 0, acc_reset_out/status_reset_out high only during reset, state FETCH.
- LDI then ADDI: program {0x1805 (LDI 5), 0x2803 (ADDI 3)} -> WRITE cycles at cycles 4 and 8; second has sel_A=00, sel_B=1, alu_op=0, acc_wr=status_wr=1 for one cycle; PC=2 afterwards.
- STO 0x010: instruction 0x0810 -> data_memory_wr_out high exactly one cycle in EXEC with operand_out=0x010; acc_wr stays 0; PC increments by 1.
- Branches: BEQ 0x020 with Z=1 -> PC=0x020; same with Z=0 -> PC+1; BLT with N=1 -> taken; BGE with N=1 -> not taken.
- Wrap and halt: JMP 0x7FF, NOP at 0x7FF -> PC=0x000; HLT -> halted_out=1 and PC frozen for 10+ cycles.
- Reset mid-EXEC of ADD -> no acc_wr pulse, PC=0 next cycle, normal fetch resumes.
